// File: rtl/imem_loadable_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Default widths match the global ISIZE / MEM_SPACE defines.
package imem_loadable_pkg;

    localparam int unsigned ISIZE_DEF     = 16;
    localparam int unsigned MEM_SPACE_DEF = 8;

    localparam logic [ISIZE_DEF-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        StClear,
        StLoad,
        StRun
    } state_e;

endpackage

// File: rtl/imem_loadable_if.sv
// Fetch and program-load signals of the instruction memory.
// master = loader / IF stage side, slave = memory side.
interface imem_loadable_if #(
    parameter int unsigned ISIZE     = 16,
    parameter int unsigned MEM_SPACE = 8
) ();

    logic                 fetch_req;
    logic [MEM_SPACE-1:0] fetch_addr;
    logic                 fetch_valid;
    logic [ISIZE-1:0]     fetch_data;

    logic                 load_start;
    logic                 load_valid;
    logic [ISIZE-1:0]     load_data;
    logic                 load_ready;
    logic                 load_done;
    logic [MEM_SPACE:0]   load_count;
    logic                 load_overflow;
    logic                 busy;

    modport master (
        output fetch_req, fetch_addr, load_start, load_valid, load_data, load_done,
        input  fetch_valid, fetch_data, load_ready, load_count, load_overflow, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_done,
        output fetch_valid, fetch_data, load_ready, load_count, load_overflow, busy
    );

endinterface

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM with registered read data.
// Only the read register is reset; array contents are not.
module imem_sp_ram #(
    parameter int unsigned ISIZE     = 16,
    parameter int unsigned MEM_SPACE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [MEM_SPACE-1:0] addr,
    input  logic [ISIZE-1:0]     wdata,
    output logic [ISIZE-1:0]     rdata
);

    logic [ISIZE-1:0] mem [2**MEM_SPACE];
    logic [ISIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with hardware zero-fill sweep, run-time program load
// port and a one-cycle-latency fetch port.
module imem_loadable
    import imem_loadable_pkg::*;
#(
    parameter int unsigned ISIZE         = ISIZE_DEF,
    parameter int unsigned MEM_SPACE     = MEM_SPACE_DEF,
    parameter bit          CLEAR_ON_LOAD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    imem_loadable_if.slave  bus
);

    localparam logic [MEM_SPACE:0]   DepthCnt = {1'b1, {MEM_SPACE{1'b0}}};
    localparam logic [MEM_SPACE-1:0] LastAddr = '1;

    state_e               st_q, st_d;
    logic [MEM_SPACE-1:0] clr_ptr_q, clr_ptr_d;
    logic                 ret_load_q, ret_load_d;
    logic [MEM_SPACE:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q;
    logic                 fvalid_q;
    logic                 load_ready;

    logic                 ram_we;
    logic                 ram_re;
    logic [MEM_SPACE-1:0] ram_addr;
    logic [ISIZE-1:0]     ram_wdata;

    assign load_ready = (st_q == StLoad) && (cnt_q < DepthCnt);

    always_comb begin
        st_d       = st_q;
        clr_ptr_d  = clr_ptr_q;
        ret_load_d = ret_load_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = bus.fetch_addr;
        ram_wdata  = ISIZE'(NOP_INSTR);

        unique case (st_q)
            StClear: begin
                ram_we    = 1'b1;
                ram_addr  = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastAddr) begin
                    st_d       = ret_load_q ? StLoad : StRun;
                    ret_load_d = 1'b0;
                end
            end
            StLoad: begin
                ram_addr  = cnt_q[MEM_SPACE-1:0];
                ram_wdata = bus.load_data;
                if (bus.load_start && !bus.load_done) begin
                    // Restart drops any word offered in the same cycle.
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (CLEAR_ON_LOAD) begin
                        st_d       = StClear;
                        clr_ptr_d  = '0;
                        ret_load_d = 1'b1;
                    end
                end else begin
                    if (bus.load_valid && load_ready) begin
                        ram_we = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (bus.load_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (bus.load_done) begin
                        st_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.load_start) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (CLEAR_ON_LOAD) begin
                        st_d       = StClear;
                        clr_ptr_d  = '0;
                        ret_load_d = 1'b1;
                    end else begin
                        st_d = StLoad;
                    end
                end else begin
                    ram_re = bus.fetch_req;
                end
            end
            default: st_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= StClear;
            clr_ptr_q  <= '0;
            ret_load_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            fvalid_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            clr_ptr_q  <= clr_ptr_d;
            ret_load_q <= ret_load_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= (st_d != StRun);
            fvalid_q   <= (st_q == StRun) && bus.fetch_req && !bus.load_start;
        end
    end

    imem_sp_ram #(
        .ISIZE     (ISIZE),
        .MEM_SPACE (MEM_SPACE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (bus.fetch_data)
    );

    assign bus.fetch_valid   = fvalid_q;
    assign bus.load_ready    = load_ready;
    assign bus.load_count    = cnt_q;
    assign bus.load_overflow = ovf_q;
    assign bus.busy          = busy_q;

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed 16-bit instruction memory.
- Width and depth are generic; the power-on zero-fill is a hardware sweep rather than a simulation-only file read.
- Adds a run-time program-load port with a valid/ready handshake, and a fetch port with a registered request/valid response.
- Sits between the program loader (bench or debug UART) and the IF stage of the pipeline.

Parameters:
- ISIZE, 16, instruction word width in bits.
- MEM_SPACE, 8, address width; DEPTH = 2**MEM_SPACE words.
- CLEAR_ON_LOAD, 1, when 1 every load_start first zero-fills the whole array before accepting words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- fetch_req  in  1  fetch request, sampled at rising edge.
- fetch_addr  in  MEM_SPACE  fetch word address.
- fetch_valid  out  1  fetch_data holds a valid word this cycle.
- fetch_data  out  ISIZE  fetched instruction.
- load_start  in  1  single-cycle pulse: begin a program load.
- load_valid  in  1  load_data is valid.
- load_data  in  ISIZE  word to write at the load pointer.
- load_ready  out  1  block accepts a load word this cycle.
- load_done  in  1  single-cycle pulse: end the load and return to RUN.
- load_count  out  MEM_SPACE+1  words accepted in the current or last load.
- load_overflow  out  1  sticky: a word was offered while the array was full.
- busy  out  1  state is CLEAR or LOAD; fetches are not served.

Behaviour:
- States: CLEAR, LOAD, RUN.
- Reset (rst=0, asynchronous):
  - State goes to CLEAR and clr_ptr=0.
  - Outputs: fetch_valid=0, fetch_data=0, load_ready=0, load_count=0, load_overflow=0, busy=1.
  - Array contents are not reset asynchronously; the CLEAR sweep zeroes them.
- CLEAR:
  - Writes 0 to mem[clr_ptr] each cycle, then increments clr_ptr.
  - After writing DEPTH-1 (DEPTH cycles total), moves to LOAD if the sweep was entered from load_start, otherwise to RUN.
  - fetch_req, load_valid, load_start and load_done are all ignored.
- RUN:
  - Fetch latency is 1 cycle: fetch_req=1 at edge N gives fetch_valid=1 and fetch_data=mem[fetch_addr] after edge N.
  - fetch_req=0 gives fetch_valid=0 next cycle; fetch_data holds its last value.
  - load_start takes priority over a same-cycle fetch_req (that fetch is dropped, fetch_valid=0).
  - On load_start: load_count=0, load_overflow=0, load pointer=0; next state is CLEAR (with return to LOAD) if CLEAR_ON_LOAD=1, otherwise LOAD.
- LOAD:
  - load_ready = (load_count < DEPTH).
  - Handshake: load_valid & load_ready at an edge writes mem[load_count[MEM_SPACE-1:0]] = load_data and increments load_count.
  - load_valid & !load_ready sets load_overflow; the word is dropped.
  - load_done moves to RUN next cycle. A word accepted in the same cycle as load_done is still written.
  - load_start in LOAD restarts: pointer=0, count=0, overflow=0, and a CLEAR sweep runs first if CLEAR_ON_LOAD=1. load_done takes priority over a same-cycle load_start.
  - fetch_valid stays 0 throughout LOAD.
- Write/read collision: none is possible, because writes only occur in CLEAR/LOAD and reads only in RUN.
- Address wrap: none; the fetch address width covers exactly DEPTH words. load_count saturates at DEPTH.
- Reset mid-sweep or mid-load: the sweep restarts from 0 and partially loaded content is lost. This is the required behaviour.
- busy is registered and reflects the current state (1 in CLEAR and LOAD, 0 in RUN).

Decomposition:
- Shared package holds:
  - state encoding typedef (CLEAR, LOAD, RUN);
  - default ISIZE and MEM_SPACE, aligned with the existing global ISIZE / MEM_SPACE defines;
  - NOP/zero instruction constant.
- One sub-module, imem_sp_ram: single-port synchronous RAM (write enable, address, write data, registered read data), parametrised by ISIZE and MEM_SPACE.
- The FSM, pointers and handshake logic stay in imem_loadable.

Test Plan:
- Power-on sweep: release rst after 3 cycles (MEM_SPACE=4) -> busy=1 for exactly 16 cycles, then RUN; fetch every address -> fetch_data=0, fetch_valid one cycle after each req.
- Basic load (CLEAR_ON_LOAD=0): load_start, then 3 words 16'h1234, 16'hABCD, 16'h0F0F with load_valid held, then load_done -> load_count=3, busy=0; fetch addr 1 -> 16'hABCD next cycle.
- Overflow (MEM_SPACE=2): offer 5 words -> load_ready drops after 4 accepts, load_overflow=1, load_count=4, mem[0] holds the first word (no wrap).
- CLEAR_ON_LOAD=1 reload: preload addr 5 = 16'hBEEF, then load_start plus 2 words -> fetch addr 5 returns 0; busy spans 16+load cycles.
- Simultaneous events:
  - load_valid with load_done -> word written, RUN next cycle;
  - load_start with fetch_req in RUN -> fetch_valid stays 0.
- Reset mid-load (rst=0 after 2 of 4 words) -> outputs at reset values immediately; after the sweep, addrs 0..1 read 0.
